// File: rtl/ram_vec_pkg.sv
// Shared types for the RAM vector engine: operation codes and FSM states.
package ram_vec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_vec_alu.sv
// Combinational element operator; flag is carry-out for ADD and borrow for SUB.
module ram_vec_alu
  import ram_vec_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag
);

  // One extra bit captures carry on add and borrow (a < b) on subtract.
  function automatic logic [DATA_WIDTH:0] add_ext(input logic [DATA_WIDTH-1:0] x,
                                                  input logic [DATA_WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [DATA_WIDTH:0] sub_ext(input logic [DATA_WIDTH-1:0] x,
                                                  input logic [DATA_WIDTH-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  logic [DATA_WIDTH:0] ext;

  always_comb begin
    ext    = '0;
    result = '0;
    flag   = 1'b0;
    unique case (op)
      OP_ADD: begin
        ext    = add_ext(a, b);
        result = ext[DATA_WIDTH-1:0];
        flag   = ext[DATA_WIDTH];
      end
      OP_SUB: begin
        ext    = sub_ext(a, b);
        result = ext[DATA_WIDTH-1:0];
        flag   = ext[DATA_WIDTH];
      end
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ram_vec_engine.sv
// Command-driven vector engine: mem[dst+i] = op(mem[src0+i], mem[src1+i]), one element per clock.
module ram_vec_engine
  import ram_vec_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src0,
  input  logic [ADDR_WIDTH-1:0] cmd_src1,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] r_addr0,
  output logic [ADDR_WIDTH-1:0] r_addr1,
  input  logic [DATA_WIDTH-1:0] r_data0,
  input  logic [DATA_WIDTH-1:0] r_data1,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] src0_q, src1_q, dst_q;
  logic [ADDR_WIDTH:0]   len_q, idx_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_flag;
  logic                  last_elem;

  ram_vec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .a      (r_data0),
    .b      (r_data1),
    .result (alu_result),
    .flag   (alu_flag)
  );

  assign last_elem = (idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1}) == len_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) state_d = (cmd_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_elem) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM-side outputs are pure decodes of state so reset silences them immediately.
  always_comb begin
    r_addr0      = '0;
    r_addr1      = '0;
    w_addr       = '0;
    w_data       = '0;
    write_enable = 1'b0;
    if (state_q == S_RUN) begin
      r_addr0      = src0_q + idx_q[ADDR_WIDTH-1:0];
      r_addr1      = src1_q + idx_q[ADDR_WIDTH-1:0];
      w_addr       = dst_q + idx_q[ADDR_WIDTH-1:0];
      w_data       = alu_result;
      write_enable = 1'b1;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      src0_q  <= '0;
      src1_q  <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (cmd_valid) begin
          op_q   <= op_e'(cmd_op);
          src0_q <= cmd_src0;
          src1_q <= cmd_src1;
          dst_q  <= cmd_dst;
          len_q  <= cmd_len;
          idx_q  <= '0;
          ovf_q  <= 1'b0;
        end
        S_RUN: begin
          idx_q <= idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (alu_flag) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
